// File: rtl/sccb_target.sv
// SCCB camera-side responder: decodes 3-phase writes and 2-phase write/read
// transactions from an oversampled SCL/SDA pair and serves a 256 x 8 register file.
module sccb_target #(
  parameter logic [7:0] DEVICE_ID = 8'h42,
  parameter logic [7:0] PID_VALUE = 8'h76,
  parameter logic [7:0] VER_VALUE = 8'h73
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic       reg_wr_valid,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data
);

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned REG_DEPTH = 256;

  localparam logic [BYTE_W-1:0] PID_ADDR = 8'h0A;
  localparam logic [BYTE_W-1:0] VER_ADDR = 8'h0B;
  localparam logic [CNT_W-1:0]  BYTE_DONE = CNT_W'(8);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ID,
    S_ID_ACK,
    S_SUB,
    S_SUB_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_WAIT_STOP
  } state_t;

  state_t state_q, state_d;

  logic scl_s1, scl_s2, scl_q;
  logic sda_s1, sda_s2, sda_q;

  logic              scl_rise_c, scl_fall_c, start_c, stop_c, done_c;
  logic              match_wr_c, match_rd_c;
  logic [BYTE_W-1:0] rx_next_c, rd_val_c;

  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] tx_q, tx_d;
  logic [BYTE_W-1:0] ptr_q, ptr_d;
  logic              rd_mode_q, rd_mode_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_d;
  logic              wr_valid_d;
  logic [BYTE_W-1:0] wr_addr_d, wr_data_d;
  logic              wr_en_c;

  logic [BYTE_W-1:0] regs_q [REG_DEPTH];

  // Open-drain pad: only ever pull low or release.
  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  // Two-flop synchronisers plus one edge-history stage; idle bus is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_q  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      scl_q  <= scl_s2;
      sda_s1 <= sda;
      sda_s2 <= sda_s1;
      sda_q  <= sda_s2;
    end
  end

  // Bus event decode; START/STOP need SCL high on both samples so they never
  // coincide with an SCL edge.
  always_comb begin
    scl_rise_c = scl_s2 & ~scl_q;
    scl_fall_c = ~scl_s2 & scl_q;
    start_c    = scl_s2 & scl_q & sda_q & ~sda_s2;
    stop_c     = scl_s2 & scl_q & ~sda_q & sda_s2;
    done_c     = (bit_cnt_q == BYTE_DONE);
    rx_next_c  = {shift_q[BYTE_W-2:0], sda_s2};
    match_wr_c = (shift_q == DEVICE_ID);
    match_rd_c = (shift_q == (DEVICE_ID | 8'h01));
  end

  // Read mux: the identification pair is hard-wired.
  always_comb begin
    if (ptr_q == PID_ADDR) begin
      rd_val_c = PID_VALUE;
    end else if (ptr_q == VER_ADDR) begin
      rd_val_c = VER_VALUE;
    end else begin
      rd_val_c = regs_q[ptr_q];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; byte phases advance on the SCL fall that ends bit 8.
  always_comb begin
    state_d = state_q;
    if (stop_c) begin
      state_d = S_IDLE;
    end else if (start_c) begin
      state_d = S_ID;
    end else begin
      case (state_q)
        S_ID: begin
          if (scl_fall_c && done_c) begin
            state_d = (match_wr_c || match_rd_c) ? S_ID_ACK : S_WAIT_STOP;
          end
        end
        S_ID_ACK: begin
          if (scl_fall_c) begin
            state_d = rd_mode_q ? S_RDATA : S_SUB;
          end
        end
        S_SUB: begin
          if (scl_fall_c && done_c) begin
            state_d = S_SUB_ACK;
          end
        end
        S_SUB_ACK: begin
          if (scl_fall_c) begin
            state_d = S_WDATA;
          end
        end
        S_WDATA: begin
          if (scl_fall_c && done_c) begin
            state_d = S_WDATA_ACK;
          end
        end
        S_WDATA_ACK: begin
          if (scl_fall_c) begin
            state_d = S_WAIT_STOP;
          end
        end
        S_RDATA: begin
          if (scl_fall_c && done_c) begin
            state_d = S_RDATA_ACK;
          end
        end
        S_RDATA_ACK: begin
          if (scl_fall_c) begin
            state_d = S_WAIT_STOP;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Output and datapath control: bit shifting, ACK drive, read serialisation.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    rd_mode_d  = rd_mode_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy;
    wr_valid_d = 1'b0;
    wr_addr_d  = reg_wr_addr;
    wr_data_d  = reg_wr_data;
    wr_en_c    = 1'b0;
    if (stop_c) begin
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
    end else if (start_c) begin
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
      shift_d   = '0;
    end else begin
      case (state_q)
        S_ID, S_SUB, S_WDATA: begin
          if (scl_rise_c && !done_c) begin
            shift_d   = rx_next_c;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if ((state_q == S_WDATA) && (bit_cnt_q == CNT_W'(7))) begin
              wr_valid_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = rx_next_c;
              wr_en_c    = 1'b1;
            end
          end
          if (scl_fall_c && done_c) begin
            bit_cnt_d = '0;
            if (state_q == S_ID) begin
              if (match_wr_c || match_rd_c) begin
                sda_oe_d  = 1'b1;
                busy_d    = 1'b1;
                rd_mode_d = match_rd_c;
              end else begin
                sda_oe_d = 1'b0;
              end
            end else begin
              if (state_q == S_SUB) begin
                ptr_d = shift_q;
              end
              sda_oe_d = 1'b1;
            end
          end
        end
        S_ID_ACK, S_SUB_ACK, S_WDATA_ACK: begin
          if (scl_fall_c) begin
            sda_oe_d = 1'b0;
            if ((state_q == S_ID_ACK) && rd_mode_q) begin
              tx_d     = rd_val_c;
              sda_oe_d = ~rd_val_c[BYTE_W-1];
            end
          end
        end
        S_RDATA: begin
          if (scl_rise_c && !done_c) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
          if (scl_fall_c) begin
            if (done_c) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
            end else begin
              tx_d     = {tx_q[BYTE_W-2:0], 1'b0};
              sda_oe_d = ~tx_q[BYTE_W-2];
            end
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tx_q         <= '0;
      ptr_q        <= '0;
      rd_mode_q    <= 1'b0;
      sda_oe_q     <= 1'b0;
      busy         <= 1'b0;
      reg_wr_valid <= 1'b0;
      reg_wr_addr  <= '0;
      reg_wr_data  <= '0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      ptr_q        <= ptr_d;
      rd_mode_q    <= rd_mode_d;
      sda_oe_q     <= sda_oe_d;
      busy         <= busy_d;
      reg_wr_valid <= wr_valid_d;
      reg_wr_addr  <= wr_addr_d;
      reg_wr_data  <= wr_data_d;
    end
  end

  // Register file; the read-only pair is never stored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_c && (ptr_q != PID_ADDR) && (ptr_q != VER_ADDR)) begin
      regs_q[ptr_q] <= rx_next_c;
    end
  end

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: bit-banged SCCB initiator plus a register-file model.
module tb_sccb_target;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl = 1'b1;
  logic       sda_low = 1'b0;
  wire        sda;
  logic       busy;
  logic       reg_wr_valid;
  logic [7:0] reg_wr_addr;
  logic [7:0] reg_wr_data;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  model_regs [256];
  logic [7:0]  model_ptr;
  logic [15:0] exp_q [$];
  logic [15:0] got_q [$];
  int          run_len = 0;
  int          max_run = 0;

  logic       ack;
  logic [7:0] rbyte;
  logic [7:0] a, d, id;
  int         kind;

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  sccb_target dut (
    .clk          (clk),
    .reset        (reset),
    .scl          (scl),
    .sda          (sda),
    .busy         (busy),
    .reg_wr_valid (reg_wr_valid),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data)
  );

  always #5 clk = ~clk;

  // Capture every write pulse and track the longest run of consecutive highs.
  always @(negedge clk) begin
    if (reg_wr_valid === 1'b1) begin
      got_q.push_back({reg_wr_addr, reg_wr_data});
      run_len = run_len + 1;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] p);
    if (p == 8'h0A) return 8'h76;
    if (p == 8'h0B) return 8'h73;
    return model_regs[p];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model_regs[i] = 8'h00;
    model_ptr = 8'h00;
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      sda_low = 1'b0;
      wait_cyc(5);
      scl = 1'b1;
    end
    wait_cyc(10);
    sda_low = 1'b1;
    wait_cyc(10);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_cyc(5);
    sda_low = 1'b1;
    wait_cyc(5);
    scl = 1'b1;
    wait_cyc(10);
    sda_low = 1'b0;
    wait_cyc(10);
  endtask

  task automatic send_bit(input logic b);
    wait_cyc(5);
    sda_low = ~b;
    wait_cyc(5);
    scl = 1'b1;
    wait_cyc(10);
    scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic chk_rel, output logic got_ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_low = 1'b0;
    wait_cyc(5);
    scl = 1'b1;
    wait_cyc(5);
    got_ack = (sda === 1'b0);
    wait_cyc(5);
    scl = 1'b0;
    if (chk_rel) begin
      wait_cyc(5);
      check("ack_release", 32'(sda), 32'(1'b1));
    end
  endtask

  task automatic recv_byte(output logic [7:0] b);
    sda_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      wait_cyc(10);
      scl = 1'b1;
      wait_cyc(5);
      b[i] = (sda !== 1'b0);
      wait_cyc(5);
      scl = 1'b0;
    end
    wait_cyc(10);
    scl = 1'b1;
    wait_cyc(5);
    check("rd_9th_released", 32'(sda), 32'(1'b1));
    wait_cyc(5);
    scl = 1'b0;
  endtask

  task automatic flush_writes();
    check("wr_count", 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check("wr_addr_data", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_write3(input logic [7:0] addr, input logic [7:0] data);
    bus_start();
    send_byte(8'h42, 1'b1, ack);
    check("w3_id_ack", 32'(ack), 32'(1'b1));
    check("w3_busy", 32'(busy), 32'(1'b1));
    send_byte(addr, 1'b1, ack);
    check("w3_sub_ack", 32'(ack), 32'(1'b1));
    exp_q.push_back({addr, data});
    send_byte(data, 1'b1, ack);
    check("w3_data_ack", 32'(ack), 32'(1'b1));
    bus_stop();
    check("w3_busy_after_stop", 32'(busy), 32'(1'b0));
    model_ptr = addr;
    if (addr != 8'h0A && addr != 8'h0B) model_regs[addr] = data;
    flush_writes();
  endtask

  task automatic do_write2(input logic [7:0] addr);
    bus_start();
    send_byte(8'h42, 1'b1, ack);
    check("w2_id_ack", 32'(ack), 32'(1'b1));
    send_byte(addr, 1'b1, ack);
    check("w2_sub_ack", 32'(ack), 32'(1'b1));
    bus_stop();
    model_ptr = addr;
    flush_writes();
  endtask

  task automatic do_read();
    bus_start();
    send_byte(8'h43, 1'b0, ack);
    check("rd_id_ack", 32'(ack), 32'(1'b1));
    recv_byte(rbyte);
    check("rd_data", 32'(rbyte), 32'(model_read(model_ptr)));
    check("rd_busy", 32'(busy), 32'(1'b1));
    bus_stop();
    check("rd_busy_after_stop", 32'(busy), 32'(1'b0));
  endtask

  task automatic do_bad(input logic [7:0] bid, input logic [7:0] addr, input logic [7:0] data);
    bus_start();
    send_byte(bid, 1'b1, ack);
    check("bad_id_nack", 32'(ack), 32'(1'b0));
    check("bad_busy", 32'(busy), 32'(1'b0));
    send_byte(addr, 1'b1, ack);
    check("bad_sub_nack", 32'(ack), 32'(1'b0));
    send_byte(data, 1'b1, ack);
    check("bad_data_nack", 32'(ack), 32'(1'b0));
    bus_stop();
    flush_writes();
  endtask

  initial begin
    model_reset();
    wait_cyc(4);
    check("rst_sda", 32'(sda), 32'(1'b1));
    check("rst_busy", 32'(busy), 32'(1'b0));
    check("rst_wr_valid", 32'(reg_wr_valid), 32'(1'b0));
    check("rst_wr_addr", 32'(reg_wr_addr), 32'h0);
    check("rst_wr_data", 32'(reg_wr_data), 32'h0);
    reset = 1'b1;
    wait_cyc(10);

    // Directed cases from the plan.
    do_read();
    do_write3(8'h12, 8'h80);
    do_write2(8'h12);
    do_read();
    do_write2(8'h0A);
    do_read();
    do_write3(8'h0B, 8'h55);
    do_write2(8'h0B);
    do_read();
    do_bad(8'h60, 8'h12, 8'h81);
    do_write2(8'h12);
    do_read();

    // Randomised transaction mix.
    for (int t = 0; t < 30; t++) begin
      kind = int'($urandom_range(0, 3));
      a = 8'($urandom);
      if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) == 0) ? 8'h0A : 8'h0B;
      d = 8'($urandom);
      case (kind)
        0: do_write3(a, d);
        1: begin do_write2(a); do_read(); end
        2: do_read();
        default: begin
          id = 8'($urandom);
          while (id == 8'h42 || id == 8'h43) id = 8'($urandom);
          do_bad(id, a, d);
        end
      endcase
    end

    // Reset while the target holds the SUB ACK low: release must be asynchronous.
    bus_start();
    send_byte(8'h42, 1'b1, ack);
    for (int i = 7; i >= 0; i--) send_bit(a[i]);
    sda_low = 1'b0;
    wait_cyc(5);
    scl = 1'b1;
    wait_cyc(3);
    check("pre_reset_ack_low", 32'(sda), 32'(1'b0));
    reset = 1'b0;
    #1;
    check("async_release", 32'(sda), 32'(1'b1));
    check("reset_busy", 32'(busy), 32'(1'b0));
    wait_cyc(5);
    reset = 1'b1;
    model_reset();
    wait_cyc(5);
    do_read();
    do_write2(8'h12);
    do_read();

    // Reset during bit 3 of a data byte, then a clean write completes.
    bus_start();
    send_byte(8'h42, 1'b1, ack);
    send_byte(8'h20, 1'b1, ack);
    d = 8'h33;
    for (int i = 7; i >= 4; i--) send_bit(d[i]);
    reset = 1'b0;
    #1;
    check("mid_data_busy", 32'(busy), 32'(1'b0));
    check("mid_data_wr_valid", 32'(reg_wr_valid), 32'(1'b0));
    sda_low = 1'b0;
    scl = 1'b1;
    #1;
    check("mid_data_sda", 32'(sda), 32'(1'b1));
    wait_cyc(5);
    reset = 1'b1;
    model_reset();
    wait_cyc(5);
    flush_writes();
    do_write3(8'h20, 8'h33);
    do_write2(8'h20);
    do_read();

    check("wr_pulse_width", 32'(max_run), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sccb_target.md
# sccb_target

Synthesizable SCCB (OV7670-style) responder: the camera end of the bus driven by `sccb_control`. It oversamples SCL/SDA on the system clock, decodes 3-phase write and 2-phase write/read transactions, ACKs the configured device ID, and maintains a 256 x 8 register file. It is used as the in-fabric camera stand-in for closed-loop simulation of `sccb_control` and for loopback bring-up on the board.

## Interface
- `DEVICE_ID`, 8'h42: write address byte; read address is `DEVICE_ID | 1` (8'h43).
- `PID_VALUE`, 8'h76: read-only contents of register 0x0A.
- `VER_VALUE`, 8'h73: read-only contents of register 0x0B.

- `clk`  in  1  system clock; SCL high and low phases are each ≥ 8 `clk` periods.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `scl`  in  1  SCCB clock from the initiator.
- `sda`  inout  1  open-drain data line; this block only ever drives 1'b0 or 1'bz.
- `busy`  out  1  high from an address-matched START until STOP.
- `reg_wr_valid`  out  1  one-cycle pulse per committed register write.
- `reg_wr_addr`  out  8  sub-address of the committed write.
- `reg_wr_data`  out  8  data of the committed write.

## Operation
- Synchronise `scl` and `sda` input through 2 flops each, then register once more for edge detection.
- START: synchronised SDA falls while SCL is high. STOP: synchronised SDA rises while SCL is high.
- Sample the bit on each SCL rising edge, MSB first. Change the driven SDA value only after an SCL falling edge.
- States:
  - IDLE: waits for START.
  - ID: shift 8 bits.
  - ID_ACK.
  - SUB: shift 8 bits.
  - SUB_ACK.
  - WDATA: shift 8 bits.
  - WDATA_ACK.
  - RDATA: drive 8 bits.
  - RDATA_ACK: release SDA and ignore the initiator's bit.
  - WAIT_STOP.
- ID byte handling:
  - Equals `DEVICE_ID`: go to ID_ACK, then SUB.
  - Equals `DEVICE_ID|1`: go to ID_ACK, then RDATA.
  - Anything else: release SDA, go to WAIT_STOP, keep `busy`=0.
- SUB → SUB_ACK: latch the sub-address into the internal pointer. After the ACK, go to WDATA. A STOP here ends a 2-phase write: pointer updated, no register write.
- WDATA → WDATA_ACK: commit `regs[pointer]` and pulse `reg_wr_valid`. Then go to WAIT_STOP. Any further bytes are not ACKed and not written. The pointer does not auto-increment.
- RDATA drives `regs[pointer]`: a 0 bit drives SDA low, a 1 bit releases it. RDATA_ACK then goes to WAIT_STOP.
- Read-only registers:
  - Register 0x0A always reads `PID_VALUE`; register 0x0B always reads `VER_VALUE`.
  - Writes to 0x0A or 0x0B still ACK and still pulse `reg_wr_valid`, but the stored value is unchanged.
- A START in any state, including a repeated START, goes to ID and clears the bit counter. A STOP in any state goes to IDLE and releases SDA.
- Reset values:
  - State IDLE, SDA released, `busy`=0, `reg_wr_valid`=0.
  - `reg_wr_addr`=0, `reg_wr_data`=0, pointer=0, all registers 0 except the read-only pair.
- Reset asserted mid-transaction releases SDA immediately (asynchronously). The transaction is abandoned; the block waits for the next START.

## Timing
- Input-to-decision latency: 3 `clk` cycles from a bus edge (2 synchroniser flops plus the edge register).
- ACK timing:
  - SDA is driven low within 4 `clk` of the SCL falling edge that ends bit 8.
  - It is held through the 9th SCL high phase.
  - It is released within 4 `clk` of the following SCL falling edge.
- Read data bit *n* is valid within 4 `clk` of the preceding SCL falling edge. For bit 7 that edge is the one ending the ID ACK.
- `reg_wr_valid` asserts within 4 `clk` after the SCL rising edge that samples data bit 0. The pulse lasts exactly 1 cycle; `reg_wr_addr` and `reg_wr_data` hold their values until the next write.
- `busy` rises 1 cycle after the matched ID byte completes and falls 1 cycle after the STOP is detected.
- START or STOP coincident with a bit sample: the START/STOP takes priority and the bit is discarded.

## Test plan
- Write 0x42, 0x12, 0x80, then STOP → ACK low on all three 9th bits; one `reg_wr_valid` pulse with addr 0x12 and data 0x80; a later read of 0x12 returns 0x80.
- Write 0x42, 0x0A, STOP; then read 0x43 → target drives 0x76 MSB-first; SDA released on the 9th bit; `busy` falls after STOP.
- Write 0x42, 0x0B, 0x55; then read 0x0B → ACKs and `reg_wr_valid` are present, but the read returns 0x73.
- ID 0x60, 0x12, 0x80 → SDA never driven low; `busy`=0; no write pulse; register 0x12 unchanged.
- Write 0x42, 0x20, then assert `reset` during bit 3 of the data byte → SDA released in the same cycle. After release, a new write 0x42, 0x20, 0x33 completes normally.
- Closed loop: `sccb_control` started with `start_fsm` pulsed high for 4 cycles, run for 30000 cycles → every byte ACKed. The `reg_wr_valid` sequence matches `sccb_control`'s configuration table in order.
